// File: rtl/red_pitaya_asg_burst_ctrl_if.sv
// Control/status bundle between one ASG channel's burst sequencer and the
// register bank / table pointer that surround it.
interface red_pitaya_asg_burst_ctrl_if #(
    parameter int CW = 16,
    parameter int DW = 32
);
    logic          cfg_arm_i;
    logic          cfg_stop_i;
    logic          cfg_burst_i;
    logic [CW-1:0] cfg_ncyc_i;
    logic [CW-1:0] cfg_nrep_i;
    logic [DW-1:0] cfg_dly_i;
    logic          trig_i;
    logic          tbl_wrap_i;
    logic          tbl_rst_o;
    logic          run_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    state_o;
    logic [CW-1:0] rep_cnt_o;

    modport master (
        output cfg_arm_i, cfg_stop_i, cfg_burst_i, cfg_ncyc_i, cfg_nrep_i,
               cfg_dly_i, trig_i, tbl_wrap_i,
        input  tbl_rst_o, run_o, busy_o, done_o, state_o, rep_cnt_o
    );

    modport slave (
        input  cfg_arm_i, cfg_stop_i, cfg_burst_i, cfg_ncyc_i, cfg_nrep_i,
               cfg_dly_i, trig_i, tbl_wrap_i,
        output tbl_rst_o, run_o, busy_o, done_o, state_o, rep_cnt_o
    );
endinterface

// File: rtl/red_pitaya_asg_burst_ctrl.sv
// Per-channel ASG burst sequencer: arm, start on trigger edge, run N table
// periods, wait a microsecond delay, repeat R times; drives pointer reset/run.
module red_pitaya_asg_burst_ctrl #(
    parameter int CLK_MHZ = 125,
    parameter int CW      = 16,
    parameter int DW      = 32
) (
    input  logic                              dac_clk_i,
    input  logic                              dac_rst_i,
    red_pitaya_asg_burst_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DELAY = 2'd3
    } state_t;

    localparam int            PW        = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_MHZ - 1);
    localparam logic [CW-1:0] REP_MAX   = '1;

    state_t        state_q,   state_d;
    logic          trig_q;
    logic [CW-1:0] cyc_q,     cyc_d;
    logic [CW-1:0] rep_q,     rep_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [DW-1:0] dly_cnt_q, dly_cnt_d;
    logic          burst_l_q, burst_l_d;
    logic [CW-1:0] ncyc_l_q,  ncyc_l_d;
    logic [CW-1:0] nrep_l_q,  nrep_l_d;
    logic [DW-1:0] dly_l_q,   dly_l_d;
    logic          tbl_rst_q, tbl_rst_d;
    logic          run_q,     run_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;

    logic          trig_edge;
    logic [CW-1:0] cyc_inc;
    logic [CW-1:0] rep_inc;

    assign trig_edge = bus.trig_i & ~trig_q;
    assign cyc_inc   = cyc_q + 1'b1;
    assign rep_inc   = (rep_q == REP_MAX) ? rep_q : rep_q + 1'b1;

    // NOTE: every signal driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        rep_d     = rep_q;
        presc_d   = presc_q;
        dly_cnt_d = dly_cnt_q;
        burst_l_d = burst_l_q;
        ncyc_l_d  = ncyc_l_q;
        nrep_l_d  = nrep_l_q;
        dly_l_d   = dly_l_q;
        tbl_rst_d = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.cfg_stop_i && bus.cfg_arm_i)
                    state_d = ST_ARMED;
            end

            ST_ARMED: begin
                if (bus.cfg_stop_i) begin
                    state_d = ST_IDLE;
                end else if (trig_edge) begin
                    state_d   = ST_RUN;
                    burst_l_d = bus.cfg_burst_i;
                    ncyc_l_d  = bus.cfg_ncyc_i;
                    nrep_l_d  = bus.cfg_nrep_i;
                    dly_l_d   = bus.cfg_dly_i;
                    rep_d     = '0;
                    cyc_d     = '0;
                    tbl_rst_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.cfg_stop_i) begin
                    state_d = ST_IDLE;
                end else if (bus.tbl_wrap_i && burst_l_q && (ncyc_l_q != '0)) begin
                    if (cyc_inc == ncyc_l_q) begin
                        cyc_d = '0;
                        rep_d = rep_inc;
                        if ((nrep_l_q != '0) && (rep_inc == nrep_l_q)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (dly_l_q == '0) begin
                            tbl_rst_d = 1'b1;
                        end else begin
                            state_d   = ST_DELAY;
                            presc_d   = PRESC_MAX;
                            dly_cnt_d = dly_l_q - 1'b1;
                        end
                    end else begin
                        cyc_d = cyc_inc;
                    end
                end
            end

            ST_DELAY: begin
                // Two-level count: prescaler spans one microsecond, dly_cnt the rest.
                if (bus.cfg_stop_i) begin
                    state_d = ST_IDLE;
                end else if (presc_q == '0) begin
                    if (dly_cnt_q == '0) begin
                        state_d   = ST_RUN;
                        tbl_rst_d = 1'b1;
                    end else begin
                        presc_d   = PRESC_MAX;
                        dly_cnt_d = dly_cnt_q - 1'b1;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        run_d  = (state_d == ST_RUN);
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q   <= ST_IDLE;
            trig_q    <= 1'b1;
            cyc_q     <= '0;
            rep_q     <= '0;
            presc_q   <= '0;
            dly_cnt_q <= '0;
            burst_l_q <= 1'b0;
            ncyc_l_q  <= '0;
            nrep_l_q  <= '0;
            dly_l_q   <= '0;
            tbl_rst_q <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= bus.trig_i;
            cyc_q     <= cyc_d;
            rep_q     <= rep_d;
            presc_q   <= presc_d;
            dly_cnt_q <= dly_cnt_d;
            burst_l_q <= burst_l_d;
            ncyc_l_q  <= ncyc_l_d;
            nrep_l_q  <= nrep_l_d;
            dly_l_q   <= dly_l_d;
            tbl_rst_q <= tbl_rst_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tbl_rst_o = tbl_rst_q;
    assign bus.run_o     = run_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.state_o   = state_q;
    assign bus.rep_cnt_o = rep_q;

endmodule
